// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared types and constants for the counter run controller.
//   cmd_op_e      command encoding carried on cmd_op
//   ctrl_state_e  controller FSM state (also exported on state_dbg)
//   DONE_CNT_W    width of the optional done counter (COUNTER_CTRL_STATUS_EN)
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_LOAD  = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_e;

    localparam int DONE_CNT_W = 8;
    localparam logic [DONE_CNT_W-1:0] DONE_CNT_MAX = '1;

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: divides the run time into DIV-cycle slots.
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   clr    synchronous restart of the slot (next cycle is slot position 0)
//   run    count while high, hold while low
//   tick   high for one cycle every DIV cycles while run is high; the first
//          tick comes in the DIV-th running cycle after a clr
module counter_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pos;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos <= '0;
        end else if (clr) begin
            pos <= '0;
        end else if (run) begin
            pos <= (pos == LAST) ? '0 : PW'(pos + 1'b1);
        end
    end

    assign tick = run && (pos == LAST);

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: run controller for a WIDTH-bit synchronous counter.
// Takes single-cycle commands, runs the counter up to a target at a rate set
// by the prescaler, and flags completion (one-shot or auto-reload).
//
// Command handshake: cmd_valid qualifies cmd_op/cmd_arg/auto_reload for one
// cycle; there is no ready, every command is consumed in the cycle it is
// valid and its effect shows on the registered outputs the next cycle.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   cmd_valid, cmd_op    command strobe and opcode (cmd_op_e)
//   cmd_arg              START target / LOAD value
//   auto_reload          reload mode, sampled with START
//   count                counter value fed back from the counter
//   cnt_en/clr/load      counter strobes; cnt_load_val valid with cnt_load
//   busy                 controller in RUN
//   done, err            one-cycle completion / illegal-command pulses
//   done_cnt             saturating done count (only with COUNTER_CTRL_STATUS_EN)
//   state_dbg            current FSM state
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_arg,
    input  logic                  auto_reload,
    input  logic [WIDTH-1:0]      count,
    output logic                  cnt_en,
    output logic                  cnt_clr,
    output logic                  cnt_load,
    output logic [WIDTH-1:0]      cnt_load_val,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
`ifdef COUNTER_CTRL_STATUS_EN
    output logic [DONE_CNT_W-1:0] done_cnt,
`endif
    output ctrl_state_e           state_dbg
);

    ctrl_state_e      state, state_d;
    logic [WIDTH-1:0] target, target_d;
    logic             reload, reload_d;
    logic             en_d, clr_d, load_d, done_d, err_d, busy_d;
    logic [WIDTH-1:0] load_val_d;
    logic             pre_clr, tick;
    logic             stale, match;
    logic [WIDTH-1:0] pend;
    cmd_op_e          op;

    counter_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (pre_clr),
        .run   (state == ST_RUN),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state;
        target_d   = target;
        reload_d   = reload;
        en_d       = 1'b0;
        clr_d      = 1'b0;
        load_d     = 1'b0;
        load_val_d = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pre_clr    = 1'b0;
        op         = cmd_op_e'(cmd_op);

        // count lags a clr/load strobe by one cycle, so it is not trusted then.
        stale = cnt_clr || cnt_load;
        match = (state == ST_RUN) && !stale && (count == target);
        // Value count will show next cycle given the strobe now in flight;
        // used to stop enabling before the counter overshoots the target.
        if (cnt_clr)
            pend = '0;
        else if (cnt_load)
            pend = cnt_load_val;
        else if (cnt_en)
            pend = count + WIDTH'(1);
        else
            pend = count;

        if (cmd_valid && op == CMD_CLEAR) begin
            clr_d   = 1'b1;
            pre_clr = 1'b1;
            state_d = ST_IDLE;
        end else if (cmd_valid && op == CMD_STOP && state == ST_RUN) begin
            pre_clr = 1'b1;
            state_d = ST_IDLE;
        end else begin
            if (cmd_valid && (op == CMD_START || op == CMD_LOAD)) begin
                if (state == ST_RUN) begin
                    err_d = 1'b1;
                end else if (op == CMD_START) begin
                    target_d = cmd_arg;
                    reload_d = auto_reload;
                    pre_clr  = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    load_d     = 1'b1;
                    load_val_d = cmd_arg;
                end
            end
            // A dropped START/LOAD above still lets the match be processed.
            if (state == ST_RUN) begin
                if (match) begin
                    done_d  = 1'b1;
                    pre_clr = 1'b1;
                    if (reload)
                        clr_d = 1'b1;
                    else
                        state_d = ST_DONE;
                end else begin
                    en_d = tick && (pend != target);
                end
            end
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            target       <= '0;
            reload       <= 1'b0;
            cnt_en       <= 1'b0;
            cnt_clr      <= 1'b0;
            cnt_load     <= 1'b0;
            cnt_load_val <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_d;
            target       <= target_d;
            reload       <= reload_d;
            cnt_en       <= en_d;
            cnt_clr      <= clr_d;
            cnt_load     <= load_d;
            cnt_load_val <= load_val_d;
            busy         <= busy_d;
            done         <= done_d;
            err          <= err_d;
        end
    end

`ifdef COUNTER_CTRL_STATUS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_cnt <= '0;
        end else if (cmd_valid && op == CMD_CLEAR) begin
            done_cnt <= '0;
        end else if (done_d && done_cnt != DONE_CNT_MAX) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b1;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  // ---------------- shared stimulus, per-DUT valid ----------------
  logic       cmd_valid0 = 1'b0;
  logic       cmd_valid1 = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_arg = 4'd0;
  logic       auto_reload = 1'b0;

  // d0: DIV=1, d1: DIV=2
  logic [3:0] count0 = 4'd0;
  logic [3:0] count1 = 4'd0;
  logic en0, clr0, load0, busy0, done0, err0;
  logic en1, clr1, load1, busy1, done1, err1;
  logic [3:0] lval0, lval1;
  ctrl_state_e st0, st1;
`ifdef COUNTER_CTRL_STATUS_EN
  logic [7:0] dcnt0, dcnt1;
`endif

  counter_ctrl #(.WIDTH(4), .DIV(1)) d0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid0), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .auto_reload(auto_reload), .count(count0),
    .cnt_en(en0), .cnt_clr(clr0), .cnt_load(load0), .cnt_load_val(lval0),
    .busy(busy0), .done(done0), .err(err0),
`ifdef COUNTER_CTRL_STATUS_EN
    .done_cnt(dcnt0),
`endif
    .state_dbg(st0)
  );

  counter_ctrl #(.WIDTH(4), .DIV(2)) d1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .auto_reload(auto_reload), .count(count1),
    .cnt_en(en1), .cnt_clr(clr1), .cnt_load(load1), .cnt_load_val(lval1),
    .busy(busy1), .done(done1), .err(err1),
`ifdef COUNTER_CTRL_STATUS_EN
    .done_cnt(dcnt1),
`endif
    .state_dbg(st1)
  );

  // Behavioural counters: clr > load > en, +1 wraps at 16.
  always @(posedge clk) begin
    if (clr0) count0 <= 4'd0;
    else if (load0) count0 <= lval0;
    else if (en0) count0 <= count0 + 4'd1;
    if (clr1) count1 <= 4'd0;
    else if (load1) count1 <= lval1;
    else if (en1) count1 <= count1 + 4'd1;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];
  logic [3:0] mon_e;
  int en_pulses[2] = '{0, 0};
  int done_seen[2] = '{0, 0};
  int err_seen[2]  = '{0, 0};
  int b2b1 = 0;
  logic en1_prev = 1'b0;

  // Expected count at each done pulse is popped and compared here.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (en0) begin
          en_pulses[0]++;
          checks++;
          if (clr0 || load0) begin
            errors++;
            $display("FAIL strobe_overlap0 clr=%0b load=%0b with en, required none", clr0, load0);
          end
        end
        if (en1) begin
          en_pulses[1]++;
          checks++;
          if (clr1 || load1) begin
            errors++;
            $display("FAIL strobe_overlap1 clr=%0b load=%0b with en, required none", clr1, load1);
          end
        end
        if (en1 && en1_prev) b2b1++;
        en1_prev = en1;
        if (err0) err_seen[0]++;
        if (err1) err_seen[1]++;
        if (done0) begin
          done_seen[0]++;
          checks++;
          if (exp_q0.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done0 count=%0d, required no done", count0);
          end else begin
            mon_e = exp_q0.pop_front();
            if (count0 !== mon_e) begin
              errors++;
              $display("FAIL done_count0 got %0d required %0d", count0, mon_e);
            end
          end
        end
        if (done1) begin
          done_seen[1]++;
          checks++;
          if (exp_q1.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done1 count=%0d, required no done", count1);
          end else begin
            mon_e = exp_q1.pop_front();
            if (count1 !== mon_e) begin
              errors++;
              $display("FAIL done_count1 got %0d required %0d", count1, mon_e);
            end
          end
        end
      end else begin
        en1_prev = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one command to the DUTs in mask; returns in the cycle after it was sampled.
  task automatic send(input logic [1:0] mask, input cmd_op_e op, input logic [3:0] arg, input logic ar);
    cmd_valid0  = mask[0];
    cmd_valid1  = mask[1];
    cmd_op      = op;
    cmd_arg     = arg;
    auto_reload = ar;
    @(posedge clk);
    #1;
    cmd_valid0 = 1'b0;
    cmd_valid1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int n, input int budget);
    int start;
    int cyc;
    start = done_seen[which];
    cyc = 0;
    while (done_seen[which] < start + n && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (done_seen[which] < start + n) begin
      errors++;
      $display("FAIL wait_done%0d got %0d dones required %0d within %0d cycles",
               which, done_seen[which] - start, n, budget);
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({en0, clr0, load0, lval0, busy0, done0, err0, st0} !== 11'd0) begin
      errors++;
      $display("FAIL %s_d0 outputs=%0h state=%0d required all 0, IDLE", name,
               {en0, clr0, load0, lval0, busy0, done0, err0}, st0);
    end
    checks++;
    if ({en1, clr1, load1, lval1, busy1, done1, err1, st1} !== 11'd0) begin
      errors++;
      $display("FAIL %s_d1 outputs=%0h state=%0d required all 0, IDLE", name,
               {en1, clr1, load1, lval1, busy1, done1, err1}, st1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #25;
    check_quiet("reset_held");
    #5 reset = 1'b1;
    @(posedge clk);
    #1;
    check_quiet("reset_released");
`ifdef COUNTER_CTRL_STATUS_EN
    checks++;
    if (dcnt0 !== 8'd0 || dcnt1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_done_cnt got %0d/%0d required 0", dcnt0, dcnt1);
    end
`endif
  endtask

  task automatic test_load_run();
    int base0, base1;
    send(2'b11, CMD_LOAD, 4'd3, 1'b0);
    checks++;
    if (load0 !== 1'b1 || lval0 !== 4'd3 || en0 !== 1'b0) begin
      errors++;
      $display("FAIL load_strobe0 load=%0b val=%0d en=%0b required 1/3/0", load0, lval0, en0);
    end
    base0 = en_pulses[0];
    base1 = en_pulses[1];
    exp_q0.push_back(4'd9);
    exp_q1.push_back(4'd9);
    send(2'b11, CMD_START, 4'd9, 1'b0);
    checks++;
    if (busy0 !== 1'b1 || st0 !== ST_RUN) begin
      errors++;
      $display("FAIL start_busy0 busy=%0b state=%0d required 1/RUN", busy0, st0);
    end
    wait_done(0, 1, 40);
    checks++;
    if (en_pulses[0] - base0 !== 6) begin
      errors++;
      $display("FAIL run_en_pulses0 got %0d required 6", en_pulses[0] - base0);
    end
    checks++;
    if (busy0 !== 1'b0 || st0 !== ST_DONE) begin
      errors++;
      $display("FAIL run_end0 busy=%0b state=%0d required 0/DONE", busy0, st0);
    end
    idle(3);
    checks++;
    if (count0 !== 4'd9) begin
      errors++;
      $display("FAIL count_hold0 got %0d required 9", count0);
    end
    wait_done(1, 1, 60);
    checks++;
    if (en_pulses[1] - base1 !== 6) begin
      errors++;
      $display("FAIL run_en_pulses1 got %0d required 6", en_pulses[1] - base1);
    end
  endtask

  task automatic test_wrap();
    int base, ebase;
    send(2'b01, CMD_LOAD, 4'd14, 1'b0);
    base = en_pulses[0];
    ebase = err_seen[0];
    exp_q0.push_back(4'd1);
    send(2'b01, CMD_START, 4'd1, 1'b0);
    wait_done(0, 1, 40);
    checks++;
    if (en_pulses[0] - base !== 3) begin
      errors++;
      $display("FAIL wrap_en_pulses got %0d required 3", en_pulses[0] - base);
    end
    checks++;
    if (err_seen[0] !== ebase) begin
      errors++;
      $display("FAIL wrap_err got %0d err pulses required 0", err_seen[0] - ebase);
    end
  endtask

  task automatic test_match_on_start();
    int base;
    send(2'b01, CMD_LOAD, 4'd4, 1'b0);
    base = en_pulses[0];
    exp_q0.push_back(4'd4);
    send(2'b01, CMD_START, 4'd4, 1'b0);
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("FAIL match_start_early done=%0b required 0", done0);
    end
    idle(1);
    checks++;
    if (done0 !== 1'b1 || en0 !== 1'b0) begin
      errors++;
      $display("FAIL match_start_done done=%0b en=%0b required 1/0", done0, en0);
    end
    idle(2);
    checks++;
    if (en_pulses[0] !== base || st0 !== ST_DONE) begin
      errors++;
      $display("FAIL match_start_noen en_pulses=%0d state=%0d required 0/DONE", en_pulses[0] - base, st0);
    end
  endtask

  task automatic test_clear_on_match();
    int dbase;
    send(2'b01, CMD_LOAD, 4'd6, 1'b0);
    dbase = done_seen[0];
    send(2'b01, CMD_START, 4'd6, 1'b0);
    send(2'b01, CMD_CLEAR, 4'd0, 1'b0);
    checks++;
    if (clr0 !== 1'b1 || done0 !== 1'b0 || st0 !== ST_IDLE || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL clear_on_match clr=%0b done=%0b state=%0d busy=%0b required 1/0/IDLE/0",
               clr0, done0, st0, busy0);
    end
    idle(3);
    checks++;
    if (done_seen[0] !== dbase || count0 !== 4'd0) begin
      errors++;
      $display("FAIL clear_after dones=%0d count=%0d required 0/0", done_seen[0] - dbase, count0);
    end
  endtask

  task automatic test_cmd_in_run();
    int ebase;
    send(2'b10, CMD_CLEAR, 4'd0, 1'b0);
    exp_q1.push_back(4'd5);
    send(2'b10, CMD_START, 4'd5, 1'b0);
    idle(2);
    ebase = err_seen[1];
    send(2'b10, CMD_START, 4'd1, 1'b0);
    checks++;
    if (err1 !== 1'b1 || st1 !== ST_RUN) begin
      errors++;
      $display("FAIL start_in_run err=%0b state=%0d required 1/RUN", err1, st1);
    end
    send(2'b10, CMD_LOAD, 4'd7, 1'b0);
    checks++;
    if (err1 !== 1'b1 || load1 !== 1'b0) begin
      errors++;
      $display("FAIL load_in_run err=%0b load=%0b required 1/0", err1, load1);
    end
    wait_done(1, 1, 60);
    checks++;
    if (err_seen[1] - ebase !== 2) begin
      errors++;
      $display("FAIL run_err_count got %0d required 2", err_seen[1] - ebase);
    end
  endtask

  task automatic test_reload();
    int base, dbase;
    send(2'b10, CMD_CLEAR, 4'd0, 1'b0);
    base = en_pulses[1];
    repeat (3) exp_q1.push_back(4'd2);
    send(2'b10, CMD_START, 4'd2, 1'b1);
    wait_done(1, 3, 100);
    send(2'b10, CMD_STOP, 4'd0, 1'b0);
    dbase = done_seen[1];
    checks++;
    if (en_pulses[1] - base !== 6) begin
      errors++;
      $display("FAIL reload_en_pulses got %0d required 6", en_pulses[1] - base);
    end
    idle(20);
    checks++;
    if (done_seen[1] !== dbase || busy1 !== 1'b0 || st1 !== ST_IDLE) begin
      errors++;
      $display("FAIL stop_after_reload dones=%0d busy=%0b state=%0d required 0/0/IDLE",
               done_seen[1] - dbase, busy1, st1);
    end
    checks++;
    if (b2b1 !== 0) begin
      errors++;
      $display("FAIL prescale_spacing got %0d back-to-back enables required 0", b2b1);
    end
  endtask

  task automatic test_reset_mid_run();
    int d0b, d1b;
    send(2'b11, CMD_CLEAR, 4'd0, 1'b0);
    send(2'b11, CMD_START, 4'd13, 1'b0);
    idle(4);
    d0b = done_seen[0];
    d1b = done_seen[1];
    #3 reset = 1'b0;
    #1;
    check_quiet("reset_mid_run");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(20);
    checks++;
    if (done_seen[0] !== d0b || done_seen[1] !== d1b || busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done dones=%0d/%0d busy=%0b/%0b required 0/0/0/0",
               done_seen[0] - d0b, done_seen[1] - d1b, busy0, busy1);
    end
  endtask

`ifdef COUNTER_CTRL_STATUS_EN
  task automatic test_done_cnt();
    int dbase;
    send(2'b01, CMD_CLEAR, 4'd0, 1'b0);
    checks++;
    if (dcnt0 !== 8'd0) begin
      errors++;
      $display("FAIL done_cnt_clear got %0d required 0", dcnt0);
    end
    repeat (300) exp_q0.push_back(4'd0);
    dbase = done_seen[0];
    send(2'b01, CMD_START, 4'd0, 1'b1);
    wait_done(0, 10, 60);
    checks++;
    if (dcnt0 !== 8'(done_seen[0] - dbase)) begin
      errors++;
      $display("FAIL done_cnt_track got %0d required %0d", dcnt0, done_seen[0] - dbase);
    end
    wait_done(0, 250, 1200);
    send(2'b01, CMD_STOP, 4'd0, 1'b0);
    exp_q0.delete();
    checks++;
    if (dcnt0 !== 8'd255) begin
      errors++;
      $display("FAIL done_cnt_sat got %0d required 255", dcnt0);
    end
    send(2'b01, CMD_CLEAR, 4'd0, 1'b0);
    checks++;
    if (dcnt0 !== 8'd0) begin
      errors++;
      $display("FAIL done_cnt_cleared got %0d required 0", dcnt0);
    end
  endtask
`endif

  task automatic test_final();
    idle(5);
    checks++;
    if (exp_q0.size() !== 0 || exp_q1.size() !== 0) begin
      errors++;
      $display("FAIL missing_done got %0d/%0d pending required 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_wrap();
    test_match_on_start();
    test_clear_on_match();
    test_cmd_in_run();
    test_reload();
    test_reset_mid_run();
`ifdef COUNTER_CTRL_STATUS_EN
    test_done_cnt();
`endif
    test_final();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
